eth_rx_frame_buffer: RTL

- Sits directly downstream of the MAC/FIFO receive AXI-Stream output (64-bit) and upstream of the MMIO register path that software reads.
- Captures whole Ethernet frames into a two-slot ping-pong buffer.
- Discards bad, oversized and no-room frames, and counts them as drops.
- Presents the oldest complete frame's byte length and random-access word reads until software pops it.

---
 rtl/eth_rx_frame_buffer_pkg.sv | 24 ++
 rtl/eth_rx_frame_buffer_if.sv | 13 +
 rtl/bsg_mem_1r1w_sync.sv | 27 ++
 rtl/eth_rx_frame_buffer_slot_tracker.sv | 59 +++++
 rtl/eth_rx_frame_buffer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/eth_rx_frame_buffer_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
// Covers the write FSM encoding, slot geometry and a byte-count helper.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_recv,
    e_drop
  } eth_rx_state_e;

  localparam int eth_rx_frame_words_gp    = 192;
  localparam int eth_rx_drop_cnt_width_gp = 16;

  // Number of valid bytes on a beat; tkeep is contiguous from the LSB.
  function automatic logic [3:0] eth_rx_keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_rx_frame_buffer_if.sv
// AXI-Stream receive channel feeding the frame buffer.
// The MAC/FIFO side is the master and the buffer is the slave.
interface eth_rx_frame_buffer_if #(parameter int data_width_p = 64);
  logic [data_width_p-1:0]   tdata;
  logic [data_width_p/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic                      tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/bsg_mem_1r1w_sync.sv
// One-read/one-write synchronous RAM with registered read data.
// Read data holds until the next read.
module bsg_mem_1r1w_sync #(
  parameter int width_p = 64,
  parameter int els_p   = 384,
  localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);
  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem_q[w_addr_i] <= w_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)    r_data_o <= '0;
    else if (r_v_i) r_data_o <= mem_q[r_addr_i];
  end
endmodule

// File: rtl/eth_rx_frame_buffer_slot_tracker.sv
// Ping-pong slot bookkeeping: head/tail pointers, valid bits and frame lengths.
// Commit and pop may land in the same cycle and always touch different slots.
module eth_rx_slot_tracker #(
  parameter int len_width_p = 11
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   commit_v_i,
  input  logic [len_width_p-1:0] commit_len_i,
  input  logic                   pop_i,
  output logic                   head_o,
  output logic                   tail_o,
  output logic                   tail_free_o,
  output logic                   frame_v_o,
  output logic [len_width_p-1:0] frame_len_o
);
  logic [1:0]             valid_q, valid_d;
  logic                   head_q, head_d, tail_q, tail_d;
  logic [len_width_p-1:0] len_q [2];
  logic                   pop_v;

  assign pop_v = pop_i & valid_q[head_q];

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop_v) begin
      valid_d[head_q] = 1'b0;
      head_d          = ~head_q;
    end
    if (commit_v_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ~tail_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_v_i) len_q[tail_q] <= commit_len_i;
  end

  assign head_o      = head_q;
  assign tail_o      = tail_q;
  assign tail_free_o = ~valid_q[tail_q];
  assign frame_v_o   = valid_q[head_q];
  assign frame_len_o = valid_q[head_q] ? len_q[head_q] : '0;
endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Captures whole Ethernet frames from AXI-Stream into a two-slot buffer and
// serves the oldest complete frame to software through word reads.
module eth_rx_frame_buffer
  import eth_rx_pkg::*;
#(
  parameter int axis_data_width_p = 64,
  parameter int frame_words_p     = eth_rx_frame_words_gp,
  localparam int addr_width_lp    = $clog2(frame_words_p),
  localparam int len_width_lp     = $clog2(frame_words_p*8+1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  eth_rx_frame_buffer_if.slave         rx_axis,
  output logic                         frame_v_o,
  output logic [len_width_lp-1:0]      frame_len_o,
  input  logic                         frame_pop_i,
  input  logic                         rd_v_i,
  input  logic [addr_width_lp-1:0]     rd_addr_i,
  output logic [axis_data_width_p-1:0] rd_data_o,
  output logic                         rd_data_v_o,
  output logic [eth_rx_drop_cnt_width_gp-1:0] drop_cnt_o
);
  localparam int cnt_width_lp      = $clog2(frame_words_p+1);
  localparam int ram_els_lp        = 2*frame_words_p;
  localparam int ram_addr_width_lp = $clog2(ram_els_lp);

  eth_rx_state_e                        state_q, state_d;
  logic [cnt_width_lp-1:0]              cnt_q, cnt_d;
  logic [eth_rx_drop_cnt_width_gp-1:0]  drop_cnt_q, drop_cnt_d;
  logic                                 tready_q;
  logic                                 rd_data_v_q, rd_zero_q;
  logic                                 beat_v, wr_v, commit_v, drop_v;
  logic [len_width_lp-1:0]              commit_len;
  logic                                 head, tail, tail_free;
  logic                                 rd_oob;
  logic [ram_addr_width_lp-1:0]         wr_addr, rd_addr;
  logic [axis_data_width_p-1:0]         ram_r_data;

  assign rx_axis.tready = tready_q;
  assign beat_v         = rx_axis.tvalid & tready_q;
  assign commit_len     = len_width_lp'({cnt_q, 3'b000})
                        + len_width_lp'(eth_rx_keep_bytes(rx_axis.tkeep));

  // cnt_q holds the words already written, so it is zero on the first beat.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_v       = 1'b0;
    commit_v   = 1'b0;
    drop_v     = 1'b0;
    if (beat_v) begin
      case (state_q)
        e_idle: begin
          if (tail_free) begin
            wr_v = 1'b1;
            if (rx_axis.tlast) begin
              commit_v = ~rx_axis.tuser;
              drop_v   = rx_axis.tuser;
            end else begin
              cnt_d   = cnt_width_lp'(1);
              state_d = e_recv;
            end
          end else if (rx_axis.tlast) begin
            drop_v = 1'b1;
          end else begin
            state_d = e_drop;
          end
        end
        e_recv: begin
          wr_v = 1'b1;
          if (rx_axis.tlast) begin
            commit_v = ~rx_axis.tuser;
            drop_v   = rx_axis.tuser;
            cnt_d    = '0;
            state_d  = e_idle;
          end else if (cnt_q == cnt_width_lp'(frame_words_p-1)) begin
            cnt_d   = '0;
            state_d = e_drop;
          end else begin
            cnt_d = cnt_q + cnt_width_lp'(1);
          end
        end
        e_drop: begin
          if (rx_axis.tlast) begin
            drop_v  = 1'b1;
            state_d = e_idle;
          end
        end
        default: state_d = e_idle;
      endcase
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_v && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= e_idle;
      cnt_q       <= '0;
      drop_cnt_q  <= '0;
      tready_q    <= 1'b0;
      rd_data_v_q <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      tready_q    <= 1'b1;
      rd_data_v_q <= rd_v_i;
      if (rd_v_i) rd_zero_q <= rd_oob;
    end
  end

  // Slots are laid out back to back, so slot 1 starts at frame_words_p.
  assign rd_oob  = int'(rd_addr_i) >= frame_words_p;
  assign wr_addr = ram_addr_width_lp'(cnt_q)
                 + (tail ? ram_addr_width_lp'(frame_words_p) : '0);
  assign rd_addr = ram_addr_width_lp'(rd_addr_i)
                 + (head ? ram_addr_width_lp'(frame_words_p) : '0);

  bsg_mem_1r1w_sync #(
    .width_p (axis_data_width_p),
    .els_p   (ram_els_lp)
  ) u_mem (
    .clk_i    (clk_i),
    .reset_i  (~reset_n_i),
    .w_v_i    (wr_v),
    .w_addr_i (wr_addr),
    .w_data_i (rx_axis.tdata),
    .r_v_i    (rd_v_i & ~rd_oob),
    .r_addr_i (rd_addr),
    .r_data_o (ram_r_data)
  );

  eth_rx_slot_tracker #(
    .len_width_p (len_width_lp)
  ) u_tracker (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .commit_v_i   (commit_v),
    .commit_len_i (commit_len),
    .pop_i        (frame_pop_i),
    .head_o       (head),
    .tail_o       (tail),
    .tail_free_o  (tail_free),
    .frame_v_o    (frame_v_o),
    .frame_len_o  (frame_len_o)
  );

  assign rd_data_o   = (rd_zero_q || !reset_n_i) ? '0 : ram_r_data;
  assign rd_data_v_o = rd_data_v_q;
  assign drop_cnt_o  = drop_cnt_q;
endmodule
